// File: rtl/qspline_udiv_pkg.sv
// Shared constants and FSM state type for the sequential restoring divider.
package qspline_udiv_pkg;

  localparam int DIN0_WIDTH_DEF = 20;
  localparam int DIN1_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/qspline_udiv_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit, then
// subtract the divisor when it fits.
module qspline_udiv_step #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // rem_in < divisor, so the restored or reduced remainder always fits WIDTH bits
  always_comb begin
    partial = {rem_in, dividend_bit};
    diff    = partial - {1'b0, divisor};
    q_bit   = (partial >= {1'b0, divisor});
    rem_out = WIDTH'(q_bit ? diff : partial);
  end

endmodule

// File: rtl/qspline_udiv_seq_20ns_10ns.sv
// Sequential unsigned divider, one quotient bit per cycle, MSB first.
// Define QSPLINE_UDIV_ZERO_SKIP_EN to short-circuit zero divisors straight to DONE.
module qspline_udiv_seq_20ns_10ns
  import qspline_udiv_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_WIDTH_DEF,
  parameter int din1_WIDTH = DIN1_WIDTH_DEF,
  parameter int dout_WIDTH = DIN0_WIDTH_DEF
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(din0_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(din0_WIDTH);

  state_t                state;
  state_t                next_state;
  logic [CNT_W-1:0]      cnt;
  logic [din0_WIDTH-1:0] dividend;
  logic [din1_WIDTH-1:0] divisor;
  logic [din1_WIDTH-1:0] part_rem;
  logic [din1_WIDTH-1:0] step_rem;
  logic                  step_q;
  logic                  divisor_zero;

  assign divisor_zero = (divisor == '0);

  qspline_udiv_step #(
    .WIDTH(din1_WIDTH)
  ) u_step (
    .rem_in      (part_rem),
    .dividend_bit(dividend[din0_WIDTH-1]),
    .divisor     (divisor),
    .rem_out     (step_rem),
    .q_bit       (step_q)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= next_state;
  end

  // RUN leaves one cycle after the final step so the last quotient bit is settled
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (ap_start) next_state = RUN;
      RUN: begin
`ifdef QSPLINE_UDIV_ZERO_SKIP_EN
        if (divisor_zero || cnt == LAST_CNT) next_state = DONE;
`else
        if (cnt == LAST_CNT) next_state = DONE;
`endif
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign ap_idle = (state == IDLE);
  assign ap_done = (state == DONE);

  // The dividend register doubles as the quotient: each step shifts a quotient bit into its LSB
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt         <= '0;
      dividend    <= '0;
      divisor     <= '0;
      part_rem    <= '0;
      dout        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            dividend <= din0;
            divisor  <= din1;
            part_rem <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          if (next_state == DONE) begin
            div_by_zero <= divisor_zero;
            dout        <= divisor_zero ? '1 : dout_WIDTH'(dividend);
            rem         <= divisor_zero ? '0 : part_rem;
          end else begin
            part_rem <= step_rem;
            dividend <= {dividend[din0_WIDTH-2:0], step_q};
            cnt      <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qspline_udiv_seq_20ns_10ns.sv
// Self-checking bench for qspline_udiv_seq_20ns_10ns: vector table, random ops,
// and hand-written sequences for ignored starts and mid-run reset.
module tb_qspline_udiv_seq_20ns_10ns;

  typedef struct {
    logic [19:0] a;
    logic [9:0]  b;
    logic [19:0] q;
    logic [9:0]  r;
    logic        z;
  } vec_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic [19:0] din0 = '0;
  logic [9:0]  din1 = '0;
  logic        ap_idle;
  logic        ap_done;
  logic [19:0] dout;
  logic [9:0]  rem;
  logic        div_by_zero;

  int compared = 0;
  int failed = 0;
  int done_count = 0;
  vec_t exp_q[$];

  qspline_udiv_seq_20ns_10ns dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .ap_start   (ap_start),
    .din0       (din0),
    .din1       (din1),
    .ap_idle    (ap_idle),
    .ap_done    (ap_done),
    .dout       (dout),
    .rem        (rem),
    .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard: every ap_done pulse must match the oldest outstanding expectation
  always begin
    @(posedge ap_clk);
    #1;
    if (ap_done) begin
      vec_t e;
      done_count++;
      if (exp_q.size() == 0) begin
        compared++;
        failed++;
        $display("[TB] FAIL unexpected_done: got done pulse, expected none (dout=%0d rem=%0d)", dout, rem);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("dout %0d/%0d", e.a, e.b), 32'(dout), 32'(e.q));
        checkOutput($sformatf("rem %0d/%0d", e.a, e.b), 32'(rem), 32'(e.r));
        checkOutput($sformatf("dbz %0d/%0d", e.a, e.b), 32'(div_by_zero), 32'(e.z));
      end
    end
  end

  function automatic int expLatency(input logic [9:0] b);
`ifdef QSPLINE_UDIV_ZERO_SKIP_EN
    return (b == 0) ? 1 : 21;
`else
    return 21;
`endif
  endfunction

  function automatic vec_t model(input logic [19:0] a, input logic [9:0] b);
    vec_t v;
    v.a = a;
    v.b = b;
    if (b == 0) begin
      v.q = 20'hFFFFF;
      v.r = '0;
      v.z = 1'b1;
    end else begin
      v.q = a / 20'(b);
      v.r = 10'(a % 20'(b));
      v.z = 1'b0;
    end
    return v;
  endfunction

  // Drive one start pulse, then return the number of edges after the capture edge until ap_done
  task automatic applyStimulus(input vec_t v, input bit expect_done, output int lat);
    if (expect_done) exp_q.push_back(v);
    @(negedge ap_clk);
    din0 = v.a;
    din1 = v.b;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    lat = -1;
    if (expect_done) begin
      for (int k = 1; k <= 60; k++) begin
        @(posedge ap_clk);
        #1;
        if (ap_done) begin
          lat = k;
          break;
        end
      end
      if (lat < 0) checkOutput("done_timeout", 32'd0, 32'd1);
      else checkOutput($sformatf("latency %0d/%0d", v.a, v.b), 32'(lat), 32'(expLatency(v.b)));
      @(posedge ap_clk);
      #1;
    end
  endtask

  vec_t table_v[12];

  initial begin
    int lat;
    int base;
    vec_t v;

    table_v[0]  = '{a: 20'd1000000, b: 10'd1000, q: 20'd1000,    r: 10'd0,   z: 1'b0};
    table_v[1]  = '{a: 20'd1048575, b: 10'd7,    q: 20'd149796,  r: 10'd3,   z: 1'b0};
    table_v[2]  = '{a: 20'd5,       b: 10'd10,   q: 20'd0,       r: 10'd5,   z: 1'b0};
    table_v[3]  = '{a: 20'd12345,   b: 10'd0,    q: 20'hFFFFF,   r: 10'd0,   z: 1'b1};
    table_v[4]  = '{a: 20'd1048575, b: 10'd1023, q: 20'd1025,    r: 10'd0,   z: 1'b0};
    table_v[5]  = '{a: 20'd100,     b: 10'd9,    q: 20'd11,      r: 10'd1,   z: 1'b0};
    table_v[6]  = '{a: 20'd0,       b: 10'd5,    q: 20'd0,       r: 10'd0,   z: 1'b0};
    table_v[7]  = '{a: 20'd1048575, b: 10'd1,    q: 20'd1048575, r: 10'd0,   z: 1'b0};
    table_v[8]  = '{a: 20'd524288,  b: 10'd512,  q: 20'd1024,    r: 10'd0,   z: 1'b0};
    table_v[9]  = '{a: 20'd999,     b: 10'd1000, q: 20'd0,       r: 10'd999, z: 1'b0};
    table_v[10] = '{a: 20'd12345,   b: 10'd1023, q: 20'd12,      r: 10'd69,  z: 1'b0};
    table_v[11] = '{a: 20'd0,       b: 10'd0,    q: 20'hFFFFF,   r: 10'd0,   z: 1'b1};

    repeat (3) @(posedge ap_clk);
    #1;
    checkOutput("reset_idle", 32'(ap_idle), 32'd1);
    checkOutput("reset_done", 32'(ap_done), 32'd0);
    checkOutput("reset_dout", 32'(dout), 32'd0);
    checkOutput("reset_rem", 32'(rem), 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
    ap_rst = 1'b0;

    for (int i = 0; i < 12; i++) applyStimulus(table_v[i], 1'b1, lat);

    for (int i = 0; i < 8; i++) begin
      v = model(20'($urandom), 10'($urandom_range(1023, 0)));
      applyStimulus(v, 1'b1, lat);
    end

    // Starts while busy (cycle 5 of RUN and during DONE) must be dropped
    base = done_count;
    exp_q.push_back(table_v[4]);
    @(negedge ap_clk);
    din0 = 20'd1048575;
    din1 = 10'd1023;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin
        din0 = 20'd77;
        din1 = 10'd3;
        ap_start = 1'b1;
      end
      @(posedge ap_clk);
      #1;
      ap_start = 1'b0;
      if (ap_done) begin
        lat = k;
        break;
      end
    end
    checkOutput("busy_latency", 32'(lat), 32'd21);
    din0 = 20'd50;
    din1 = 10'd3;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    checkOutput("done_start_idle", 32'(ap_idle), 32'd1);
    checkOutput("done_start_nodone", 32'(ap_done), 32'd0);
    repeat (25) @(posedge ap_clk);
    #1;
    checkOutput("busy_done_count", 32'(done_count - base), 32'd1);
    checkOutput("busy_hold_dout", 32'(dout), 32'd1025);
    checkOutput("busy_hold_rem", 32'(rem), 32'd0);

    // Reset at cycle 10 of RUN aborts without a done pulse
    base = done_count;
    v = model(20'd777777, 10'd13);
    applyStimulus(v, 1'b0, lat);
    repeat (9) @(posedge ap_clk);
    #1;
    checkOutput("run_not_idle", 32'(ap_idle), 32'd0);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    checkOutput("abort_idle", 32'(ap_idle), 32'd1);
    checkOutput("abort_dout", 32'(dout), 32'd0);
    checkOutput("abort_rem", 32'(rem), 32'd0);
    checkOutput("abort_dbz", 32'(div_by_zero), 32'd0);
    checkOutput("abort_done", 32'(ap_done), 32'd0);
    repeat (25) @(posedge ap_clk);
    #1;
    checkOutput("abort_no_done", 32'(done_count - base), 32'd0);
    applyStimulus(table_v[5], 1'b1, lat);

    // Reset wins over a simultaneous start
    @(negedge ap_clk);
    din0 = 20'd900;
    din1 = 10'd30;
    ap_rst = 1'b1;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    ap_start = 1'b0;
    @(posedge ap_clk);
    #1;
    checkOutput("rst_prio_idle", 32'(ap_idle), 32'd1);

    repeat (3) @(posedge ap_clk);
    #1;
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
